// File: rtl/case5_if.sv
// Stimulus/response bundle between the pattern checker (master) and the case5
// netlist plus its golden reference (slave).
interface case5_if #(
  parameter int NUM_IN  = 6,
  parameter int NUM_OUT = 3
);
  logic [NUM_IN-1:0]  vec_out;
  logic [NUM_OUT-1:0] resp_in;
  logic [NUM_OUT-1:0] golden_in;

  modport master (output vec_out, input resp_in, input golden_in);
  modport slave  (input vec_out, output resp_in, output golden_in);
endinterface

// File: rtl/case5_pattern_checker.sv
// Exhaustive sweep harness: drives every input vector, compares the delayed
// response with the golden model, and keeps a mismatch count and a MISR signature.
module case5_pattern_checker #(
  parameter int NUM_IN   = 6,
  parameter int NUM_OUT  = 3,
  parameter int RESP_LAT = 1,
  parameter int SIG_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  case5_if.master           bus,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [NUM_IN:0]   mismatch_count,
  output logic [NUM_IN-1:0] first_fail_vec,
  output logic [SIG_W-1:0]  signature
);
  typedef enum logic [1:0] {IDLE, DRIVE, DRAIN, DONE} state_t;

  localparam logic [NUM_IN-1:0] LAST_VEC = '1;
  localparam logic [2:0]        DRAIN_END = 3'(RESP_LAT - 1);

  state_t            state_reg;
  logic [NUM_IN-1:0] vec_reg;
  logic [2:0]        drain_cnt_reg;

  logic              tag_valid;
  logic [NUM_IN-1:0] tag_idx;
  logic              sample;
  logic              miss;
  logic [NUM_IN:0]   count_next;
  logic [SIG_W-1:0]  sig_next;

  assign bus.vec_out = vec_reg;

  // Each driven vector carries its index through a RESP_LAT-deep tag pipeline
  // so it arrives in step with the response it produced.
  generate
    if (RESP_LAT == 0) begin : g_comb_tag
      assign tag_valid = (state_reg == DRIVE);
      assign tag_idx   = vec_reg;
    end else begin : g_pipe_tag
      logic [RESP_LAT-1:0][NUM_IN:0] pipe_reg;
      always_ff @(posedge clk) begin
        if (rst) begin
          pipe_reg <= '0;
        end else begin
          for (int i = RESP_LAT - 1; i > 0; i--) pipe_reg[i] <= pipe_reg[i-1];
          pipe_reg[0] <= {(state_reg == DRIVE), vec_reg};
        end
      end
      assign tag_valid = pipe_reg[RESP_LAT-1][NUM_IN];
      assign tag_idx   = pipe_reg[RESP_LAT-1][NUM_IN-1:0];
    end
  endgenerate

  always_comb begin
    sample     = tag_valid && ((state_reg == DRIVE) || (state_reg == DRAIN));
    miss       = sample && (bus.resp_in != bus.golden_in);
    count_next = mismatch_count + {{NUM_IN{1'b0}}, miss};
    sig_next   = {signature[SIG_W-2:0],
                  signature[15] ^ signature[14] ^ signature[12] ^ signature[3]}
               ^ {{(SIG_W-NUM_OUT){1'b0}}, bus.resp_in};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      vec_reg        <= '0;
      drain_cnt_reg  <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      mismatch_count <= '0;
      first_fail_vec <= '0;
      signature      <= '0;
    end else begin
      done <= 1'b0;
      if (sample) begin
        mismatch_count <= count_next;
        signature      <= sig_next;
        if (miss && (mismatch_count == '0)) first_fail_vec <= tag_idx;
      end
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg      <= DRIVE;
            vec_reg        <= '0;
            busy           <= 1'b1;
            pass           <= 1'b0;
            mismatch_count <= '0;
            first_fail_vec <= '0;
            signature      <= '0;
          end
        end
        DRIVE: begin
          if (vec_reg == LAST_VEC) begin
            if (RESP_LAT == 0) begin
              state_reg <= DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
              pass      <= (count_next == '0);
            end else begin
              state_reg     <= DRAIN;
              drain_cnt_reg <= '0;
            end
          end else begin
            vec_reg <= vec_reg + 1'b1;
          end
        end
        DRAIN: begin
          // pass uses count_next so the final in-flight sample is included
          if (drain_cnt_reg == DRAIN_END) begin
            state_reg <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            pass      <= (count_next == '0);
          end else begin
            drain_cnt_reg <= drain_cnt_reg + 3'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_case5_pattern_checker.sv
// Directed bench: three checker builds (RESP_LAT 0, 1, 3) sweep a stand-in case5
// model through latency-matched delay lines.
module tb_case5_pattern_checker;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start;
  int   mode;          // 0 match, 1 inject x at inj_idx, 2 all inverted, 3 all zero
  logic [5:0] inj_idx;

  case5_if #(.NUM_IN(6), .NUM_OUT(3)) bus_l0 ();
  case5_if #(.NUM_IN(6), .NUM_OUT(3)) bus_l1 ();
  case5_if #(.NUM_IN(6), .NUM_OUT(3)) bus_l3 ();

  logic        busy [3];
  logic        done [3];
  logic        pass [3];
  logic [6:0]  mc   [3];
  logic [5:0]  ffv  [3];
  logic [15:0] sig  [3];

  case5_pattern_checker #(.RESP_LAT(0)) dut_l0 (.clk(clk), .rst(rst), .start(start), .bus(bus_l0),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]), .mismatch_count(mc[0]),
    .first_fail_vec(ffv[0]), .signature(sig[0]));
  case5_pattern_checker #(.RESP_LAT(1)) dut_l1 (.clk(clk), .rst(rst), .start(start), .bus(bus_l1),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]), .mismatch_count(mc[1]),
    .first_fail_vec(ffv[1]), .signature(sig[1]));
  case5_pattern_checker #(.RESP_LAT(3)) dut_l3 (.clk(clk), .rst(rst), .start(start), .bus(bus_l3),
    .busy(busy[2]), .done(done[2]), .pass(pass[2]), .mismatch_count(mc[2]),
    .first_fail_vec(ffv[2]), .signature(sig[2]));

  function automatic logic [2:0] case5_ref(input logic [5:0] v);
    logic x, y, z;
    x = (v[0] & v[1]) | v[2];
    y = v[3] ^ v[4] ^ v[5];
    z = ~(v[0] | v[5]) | (v[2] & v[3]);
    return {z, y, x};
  endfunction

  function automatic logic [2:0] resp_of(input int m, input logic [5:0] v);
    return (m == 3) ? 3'b000 : case5_ref(v);
  endfunction

  function automatic logic [2:0] gold_of(input int m, input logic [5:0] inj, input logic [5:0] v);
    logic [2:0] r;
    r = resp_of(m, v);
    if (m == 1 && v == inj) r = r ^ 3'b001;
    else if (m == 2) r = ~r;
    return r;
  endfunction

  // Netlist stand-in with 0, 1 and 3 cycles of registered latency.
  logic [5:0] d1;
  logic [5:0] d3 [3];
  always @(posedge clk) begin
    d1    <= bus_l1.vec_out;
    d3[0] <= bus_l3.vec_out;
    d3[1] <= d3[0];
    d3[2] <= d3[1];
  end
  assign bus_l0.resp_in   = resp_of(mode, bus_l0.vec_out);
  assign bus_l0.golden_in = gold_of(mode, inj_idx, bus_l0.vec_out);
  assign bus_l1.resp_in   = resp_of(mode, d1);
  assign bus_l1.golden_in = gold_of(mode, inj_idx, d1);
  assign bus_l3.resp_in   = resp_of(mode, d3[2]);
  assign bus_l3.golden_in = gold_of(mode, inj_idx, d3[2]);

  int nchecks = 0;
  int nerrs   = 0;
  int n_done [3];
  logic [15:0] sig_exp;
  logic [5:0]  vec_c1, vec_c6;
  logic        busy_c1, busy_c65, busy_c66, done_after;
  localparam int EXP_DONE [3] = '{65, 66, 68};

  // Starts a run in cycle T and tracks each build's done cycle relative to T.
  task automatic run_all(input int pulse_at);
    for (int i = 0; i < 3; i++) n_done[i] = -1;
    done_after = 1'b0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      start = (c == pulse_at);
      if (c == 1) begin vec_c1 = bus_l1.vec_out; busy_c1 = busy[1]; end
      if (c == 6) vec_c6 = bus_l1.vec_out;
      if (c == 65) busy_c65 = busy[1];
      if (c == 66) busy_c66 = busy[1];
      if (c == 67) done_after = done[1];
      for (int i = 0; i < 3; i++) if (done[i] && n_done[i] < 0) n_done[i] = c;
      if (c >= 70 && n_done[0] >= 0 && n_done[1] >= 0 && n_done[2] >= 0) break;
      @(posedge clk); #1;
    end
    start = 1'b0;
    $display("run mode=%0d inj=%0d done_at=%0d/%0d/%0d mc=%0d/%0d/%0d sig=%h/%h/%h",
             mode, inj_idx, n_done[0], n_done[1], n_done[2], mc[0], mc[1], mc[2],
             sig[0], sig[1], sig[2]);
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      nchecks++;
      if ({busy[i], done[i], pass[i], mc[i], ffv[i], sig[i]} !== 32'h0) begin
        nerrs++;
        $display("FAIL reset_outputs[%0d]: got busy=%b done=%b pass=%b mc=%0d ffv=%0d sig=%h, want all 0",
                 i, busy[i], done[i], pass[i], mc[i], ffv[i], sig[i]);
      end
    end
    nchecks++;
    if (bus_l1.vec_out !== 6'd0) begin
      nerrs++; $display("FAIL reset_vec: got %0d want 0", bus_l1.vec_out);
    end
    $display("reset applied");
  endtask

  task automatic check_run(input string name, input logic exp_pass, input int exp_mc,
                           input int exp_ffv, input logic [15:0] exp_sig);
    for (int i = 0; i < 3; i++) begin
      nchecks++;
      if (n_done[i] != EXP_DONE[i]) begin
        nerrs++; $display("FAIL %s_done_cycle[%0d]: got %0d want %0d", name, i, n_done[i], EXP_DONE[i]);
      end
      nchecks++;
      if (pass[i] !== exp_pass) begin
        nerrs++; $display("FAIL %s_pass[%0d]: got %b want %b", name, i, pass[i], exp_pass);
      end
      nchecks++;
      if (mc[i] !== 7'(exp_mc)) begin
        nerrs++; $display("FAIL %s_count[%0d]: got %0d want %0d", name, i, mc[i], exp_mc);
      end
      nchecks++;
      if (ffv[i] !== 6'(exp_ffv)) begin
        nerrs++; $display("FAIL %s_first_fail[%0d]: got %0d want %0d", name, i, ffv[i], exp_ffv);
      end
      nchecks++;
      if (sig[i] !== exp_sig) begin
        nerrs++; $display("FAIL %s_signature[%0d]: got %h want %h", name, i, sig[i], exp_sig);
      end
    end
  endtask

  task automatic test_match;
    mode = 0; inj_idx = 6'd0;
    run_all(0);
    check_run("match", 1'b1, 0, 0, sig_exp);
    nchecks++;
    if ({vec_c1, vec_c6} !== {6'd0, 6'd5}) begin
      nerrs++; $display("FAIL match_sweep: got vec@1=%0d vec@6=%0d want 0 and 5", vec_c1, vec_c6);
    end
    nchecks++;
    if ({busy_c1, busy_c65, busy_c66, done_after} !== 4'b1100) begin
      nerrs++; $display("FAIL match_busy_window: got busy@1,65,66,done@67=%b want 1100",
                        {busy_c1, busy_c65, busy_c66, done_after});
    end
  endtask

  task automatic test_inject(input logic [5:0] idx);
    mode = 1; inj_idx = idx;
    run_all(0);
    check_run("inject", 1'b0, 1, int'(idx), sig_exp);
  endtask

  task automatic test_all_inverted;
    mode = 2; inj_idx = 6'd0;
    run_all(0);
    check_run("inverted", 1'b0, 64, 0, sig_exp);
  endtask

  task automatic test_zero_then_repeat;
    mode = 3;
    run_all(0);
    check_run("zero", 1'b1, 0, 0, 16'h0000);
    mode = 0;
    run_all(0);
    check_run("repeat", 1'b1, 0, 0, sig_exp);
  endtask

  task automatic test_restart_ignored;
    mode = 0;
    run_all(10);
    check_run("restart", 1'b1, 0, 0, sig_exp);
  endtask

  task automatic test_reset_midrun;
    mode = 2;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (19) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      nchecks++;
      if ({busy[i], done[i], pass[i], mc[i], ffv[i], sig[i]} !== 32'h0) begin
        nerrs++;
        $display("FAIL midrun_reset[%0d]: got busy=%b done=%b pass=%b mc=%0d ffv=%0d sig=%h, want all 0",
                 i, busy[i], done[i], pass[i], mc[i], ffv[i], sig[i]);
      end
    end
    $display("reset at T+20 applied");
    mode = 0;
    run_all(0);
    check_run("after_reset", 1'b1, 0, 0, sig_exp);
  endtask

  initial begin
    logic fb;
    rst = 1'b1; start = 1'b0; mode = 0; inj_idx = 6'd0;
    sig_exp = 16'h0000;
    for (int k = 0; k < 64; k++) begin
      fb = sig_exp[15] ^ sig_exp[14] ^ sig_exp[12] ^ sig_exp[3];
      sig_exp = {sig_exp[14:0], fb} ^ {13'd0, case5_ref(6'(k))};
    end
    test_reset;
    test_match;
    test_inject(6'd5);
    test_all_inverted;
    test_zero_then_repeat;
    test_restart_ignored;
    test_reset_midrun;
    test_inject(6'd63);
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
    $finish;
  end
endmodule
